// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// selects and enables, and tracks memory-wait timeout, halt status and retired instructions.
module rv32i_mc_control #(
   parameter int MEM_TIMEOUT  = 16,
   parameter int ILLEGAL_TRAP = 1,
   parameter int RET_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       pc_sel,
   output logic [1:0]       wb_sel,
   output logic [1:0]       alu_src_a,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic [2:0]       state,
   output logic             halted,
   output logic             illegal,
   output logic             mem_timeout,
   output logic             retired,
   output logic [RET_W-1:0] ret_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [RET_W-1:0]  ret_count_q, ret_count_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              tmo_q, tmo_d;
   logic              wait_expired;

   // Counter holds the waits already spent; this not-ready cycle would be the one that hits the limit.
   assign wait_expired = (MEM_TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      // NOTE: every output and next-state signal gets a default first so no path can infer a latch.
      state_d     = state_q;
      halted_d    = halted_q;
      illegal_d   = illegal_q;
      tmo_d       = tmo_q;
      wait_d      = wait_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      pc_sel      = 2'b00;
      wb_sel      = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 1'b0;
      alu_op      = 2'b00;
      retired     = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_expired) begin
               tmo_d    = 1'b1;
               halted_d = 1'b1;
               state_d  = S_HALT;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            case (opcode)
               OPC_R: begin
                  alu_op  = 2'b10;
                  state_d = S_WB;
               end
               OPC_IMM: begin
                  alu_src_b = 1'b1;
                  alu_op    = 2'b11;
                  state_d   = S_WB;
               end
               OPC_LOAD, OPC_STORE: begin
                  alu_src_b = 1'b1;
                  state_d   = S_MEM;
               end
               OPC_LUI, OPC_AUIPC: begin
                  alu_src_a = (opcode == OPC_LUI) ? 2'b10 : 2'b01;
                  alu_src_b = 1'b1;
                  state_d   = S_WB;
               end
               OPC_JAL, OPC_JALR: state_d = S_WB;
               OPC_BRANCH: begin
                  alu_op   = 2'b01;
                  pc_write = 1'b1;
                  pc_sel   = branch_taken ? 2'b01 : 2'b00;
                  retired  = 1'b1;
                  state_d  = S_FETCH;
               end
               OPC_FENCE: begin
                  pc_write = 1'b1;
                  retired  = 1'b1;
                  state_d  = S_FETCH;
               end
               OPC_SYSTEM: begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
               default: begin
                  illegal_d = 1'b1;
                  if (ILLEGAL_TRAP != 0) begin
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else begin
                     pc_write = 1'b1;
                     retired  = 1'b1;
                     state_d  = S_FETCH;
                  end
               end
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OPC_STORE);
            if (mem_ready) begin
               if (opcode == OPC_STORE) begin
                  pc_write = 1'b1;
                  retired  = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d  = S_WB;
               end
            end else if (wait_expired) begin
               tmo_d    = 1'b1;
               halted_d = 1'b1;
               state_d  = S_HALT;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retired   = 1'b1;
            wb_sel    = (opcode == OPC_LOAD) ? 2'b01 :
                        ((opcode == OPC_JAL) || (opcode == OPC_JALR)) ? 2'b10 : 2'b00;
            pc_sel    = (opcode == OPC_JAL) ? 2'b01 : (opcode == OPC_JALR) ? 2'b10 : 2'b00;
            state_d   = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
         retired   = 1'b0;
      end

      if (state_d != state_q) begin
         wait_d = '0;
      end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
         wait_d = wait_q + 1'b1;
      end

      ret_count_d = retired ? ret_count_q + 1'b1 : ret_count_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      if (reset) begin
         state_q     <= S_FETCH;
         wait_q      <= '0;
         ret_count_q <= '0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         ret_count_q <= ret_count_d;
         halted_q    <= halted_d;
         illegal_q   <= illegal_d;
         tmo_q       <= tmo_d;
      end
   end

   assign state       = state_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign mem_timeout = tmo_q;
   assign ret_count   = ret_count_q;

endmodule
